// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: framed command receiver for the USB CDC byte stream.
// Frame: AA 55 cmd len_hi len_lo payload[len] checksum (sum of cmd..payload).
module cmd_frame_parser #(
    parameter int MAX_LEN        = 256,
    parameter int TIMEOUT_CYCLES = 600000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  usb_data_in,
    input  logic        usb_data_valid_in,
    output logic        cmd_start,
    output logic [7:0]  cmd_type,
    output logic [15:0] cmd_length,
    output logic [7:0]  cmd_data,
    output logic        cmd_data_valid,
    output logic [15:0] cmd_data_index,
    output logic        cmd_done,
    output logic        cmd_error,
    output logic        parser_busy
);

    typedef enum logic [2:0] {
        IDLE, HDR2, CMD, LEN_H, LEN_L, DATA, CKSUM
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [16:0] MAX_L = 17'(MAX_LEN);

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] tcnt;
    logic [7:0]    sum;
    logic [7:0]    type_hold;
    logic [7:0]    len_hi;
    logic [15:0]   data_cnt;

    logic          timeout;
    logic          accept;
    logic [15:0]   len_now;
    logic          too_long;
    logic          last_data;

    logic          start_d;
    logic          dv_d;
    logic          done_d;
    logic          error_d;

    // A timeout wins over any byte arriving in the same cycle.
    assign timeout   = (state != IDLE) && (tcnt == T_LIMIT);
    assign accept    = usb_data_valid_in && !timeout;
    assign len_now   = {len_hi, usb_data_in};
    assign too_long  = {1'b0, len_now} > MAX_L;
    assign last_data = data_cnt == (cmd_length - 16'd1);

    // State register and frame datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            tcnt           <= '0;
            sum            <= '0;
            type_hold      <= '0;
            len_hi         <= '0;
            data_cnt       <= '0;
            cmd_start      <= 1'b0;
            cmd_type       <= '0;
            cmd_length     <= '0;
            cmd_data       <= '0;
            cmd_data_valid <= 1'b0;
            cmd_data_index <= '0;
            cmd_done       <= 1'b0;
            cmd_error      <= 1'b0;
            parser_busy    <= 1'b0;
        end else begin
            state          <= state_next;
            cmd_start      <= start_d;
            cmd_data_valid <= dv_d;
            cmd_done       <= done_d;
            cmd_error      <= error_d;
            parser_busy    <= state_next != IDLE;

            if (state == IDLE || usb_data_valid_in || timeout)
                tcnt <= '0;
            else
                tcnt <= tcnt + 1'b1;

            if (accept) begin
                unique case (state)
                    CMD: begin
                        type_hold <= usb_data_in;
                        sum       <= usb_data_in;
                    end
                    LEN_H: begin
                        len_hi <= usb_data_in;
                        sum    <= sum + usb_data_in;
                    end
                    LEN_L: sum <= sum + usb_data_in;
                    DATA:  sum <= sum + usb_data_in;
                    default: ;
                endcase
            end

            if (start_d) begin
                cmd_type   <= type_hold;
                cmd_length <= len_now;
                data_cnt   <= '0;
            end

            if (dv_d) begin
                cmd_data       <= usb_data_in;
                cmd_data_index <= data_cnt;
                data_cnt       <= data_cnt + 16'd1;
            end
        end
    end

    // Next-state decode; bytes only move the FSM when strobed.
    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = IDLE;
        end else if (usb_data_valid_in) begin
            unique case (state)
                IDLE:
                    if (usb_data_in == 8'hAA) state_next = HDR2;
                HDR2:
                    if (usb_data_in == 8'h55)      state_next = CMD;
                    else if (usb_data_in != 8'hAA) state_next = IDLE;
                CMD:   state_next = LEN_H;
                LEN_H: state_next = LEN_L;
                LEN_L:
                    if (too_long)             state_next = IDLE;
                    else if (len_now == 16'd0) state_next = CKSUM;
                    else                       state_next = DATA;
                DATA:
                    if (last_data) state_next = CKSUM;
                CKSUM: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Pulse/strobe decode, registered one cycle later above.
    always_comb begin
        start_d = 1'b0;
        dv_d    = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
        if (timeout) begin
            error_d = 1'b1;
        end else if (accept) begin
            unique case (state)
                LEN_L: begin
                    start_d = !too_long;
                    error_d = too_long;
                end
                DATA:  dv_d = 1'b1;
                CKSUM: begin
                    done_d  = usb_data_in == sum;
                    error_d = usb_data_in != sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// tb_cmd_frame_parser: directed and random frames against a byte-buffer
// reference model of the frame rules.
module tb_cmd_frame_parser;

    localparam int MAX_LEN = 256;
    localparam int TO      = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  usb_data_in = '0;
    logic        usb_data_valid_in = 1'b0;
    logic        cmd_start;
    logic [7:0]  cmd_type;
    logic [15:0] cmd_length;
    logic [7:0]  cmd_data;
    logic        cmd_data_valid;
    logic [15:0] cmd_data_index;
    logic        cmd_done;
    logic        cmd_error;
    logic        parser_busy;

    cmd_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .usb_data_in(usb_data_in),
        .usb_data_valid_in(usb_data_valid_in),
        .cmd_start(cmd_start),
        .cmd_type(cmd_type),
        .cmd_length(cmd_length),
        .cmd_data(cmd_data),
        .cmd_data_valid(cmd_data_valid),
        .cmd_data_index(cmd_data_index),
        .cmd_done(cmd_done),
        .cmd_error(cmd_error),
        .parser_busy(parser_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // observed pulse counters, cleared per directed case
    int n_start, n_dv, n_done, n_err;

    // reference model state
    logic [7:0]  q[$];
    int          tc;
    logic        e_start, e_dv, e_done, e_err, e_busy, e_rst;
    logic [7:0]  e_type, e_data;
    logic [15:0] e_len, e_idx;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic v, input logic [7:0] b, input logic r);
        int n;
        int len;
        int s;
        int tc_n;
        logic hit;
        e_start = 0; e_dv = 0; e_done = 0; e_err = 0; e_rst = 0;
        if (!r) begin
            q.delete();
            tc = 0;
            e_type = 0; e_len = 0; e_data = 0; e_idx = 0;
            e_busy = 0; e_rst = 1;
            return;
        end
        hit = (q.size() != 0) && (tc == TO);
        tc_n = (q.size() == 0 || v || hit) ? 0 : tc + 1;
        if (hit) begin
            e_err = 1;
            q.delete();
        end else if (v) begin
            n = q.size();
            if (n == 0) begin
                if (b == 8'hAA) q.push_back(b);
            end else if (n == 1) begin
                if (b == 8'h55) q.push_back(b);
                else if (b != 8'hAA) q.delete();
            end else begin
                q.push_back(b);
                n = q.size();
                len = {q[3], q[4]};
                if (n == 5) begin
                    if (len > MAX_LEN) begin
                        e_err = 1;
                        q.delete();
                    end else begin
                        e_start = 1;
                        e_type  = q[2];
                        e_len   = 16'(len);
                    end
                end else if (n > 5) begin
                    if (n <= 5 + len) begin
                        e_dv   = 1;
                        e_data = b;
                        e_idx  = 16'(n - 6);
                    end else begin
                        s = 0;
                        for (int i = 2; i <= n - 2; i++) s += q[i];
                        if ((s % 256) == b) e_done = 1;
                        else e_err = 1;
                        q.delete();
                    end
                end
            end
        end
        tc = tc_n;
        e_busy = q.size() != 0;
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic r);
        @(negedge clk);
        check("pulses",
              {cmd_start, cmd_data_valid, cmd_done, cmd_error, parser_busy},
              {e_start, e_dv, e_done, e_err, e_busy});
        check("hdr", {cmd_type, cmd_length}, {e_type, e_len});
        if (e_dv || e_rst)
            check("data", {cmd_data, cmd_data_index}, {e_data, e_idx});
        n_start += int'(cmd_start);
        n_dv    += int'(cmd_data_valid);
        n_done  += int'(cmd_done);
        n_err   += int'(cmd_error);
        rst_n = r;
        usb_data_valid_in = v;
        usb_data_in = v ? b : 8'($urandom_range(0, 255));
        model(v, b, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic send(input logic [7:0] s[$], input int gap);
        foreach (s[i]) begin
            step(1'b1, s[i], 1'b1);
            idle(gap);
        end
    endtask

    task automatic clr();
        n_start = 0; n_dv = 0; n_done = 0; n_err = 0;
    endtask

    task automatic rand_frame();
        logic [7:0] f[$];
        int kind;
        int len;
        int s;
        kind = $urandom_range(0, 9);
        f = '{8'hAA, 8'h55, 8'($urandom_range(0, 255))};
        if (kind <= 6) len = $urandom_range(0, 6);
        else if (kind == 7) len = $urandom_range(254, 258);
        else len = $urandom_range(0, 3);
        f.push_back(8'(len >> 8));
        f.push_back(8'(len));
        for (int i = 0; i < len; i++) f.push_back(8'($urandom_range(0, 255)));
        s = 0;
        for (int i = 2; i < f.size(); i++) s += f[i];
        f.push_back(kind == 9 ? 8'(s + 1) : 8'(s));
        if (kind == 8) begin
            for (int i = 0; i < 3; i++) f.push_front(8'($urandom_range(0, 255)));
        end
        foreach (f[i]) begin
            step(1'b1, f[i], 1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 199) == 0) idle(TO + 5);
            if ($urandom_range(0, 299) == 0) step(1'b0, 8'h00, 1'b0);
        end
    endtask

    logic [7:0] good[$];

    initial begin
        model(1'b0, 8'h00, 1'b0);
        clr();
        good = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h02, 8'h10, 8'h20, 8'h33};
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        idle(2);

        clr();
        send(good, 0);
        idle(3);
        check("r33_start", 64'(n_start), 1);
        check("r33_dv", 64'(n_dv), 2);
        check("r33_done", 64'(n_done), 1);
        check("r33_err", 64'(n_err), 0);
        check("r33_hdr", {cmd_type, cmd_length}, {8'h01, 16'd2});

        clr();
        send('{8'hAA, 8'h55, 8'h01, 8'h00, 8'h02, 8'h10, 8'h20, 8'h34}, 1);
        idle(3);
        check("r34_dv", 64'(n_dv), 2);
        check("r34_err", 64'(n_err), 1);
        check("r34_done", 64'(n_done), 0);

        clr();
        send('{8'hAA, 8'h55, 8'h05, 8'h00, 8'h00, 8'h05}, 0);
        idle(3);
        check("r35_start", 64'(n_start), 1);
        check("r35_dv", 64'(n_dv), 0);
        check("r35_done", 64'(n_done), 1);
        check("r35_len", 64'(cmd_length), 0);

        clr();
        send('{8'hAA, 8'h55, 8'h07, 8'h01, 8'h01}, 0);
        send(good, 0);
        idle(3);
        check("r36_start", 64'(n_start), 1);
        check("r36_err", 64'(n_err), 1);
        check("r36_done", 64'(n_done), 1);

        clr();
        send('{8'h12, 8'hAA, 8'h34, 8'hAA, 8'hAA, 8'h55}, 0);
        send(good[2:$], 0);
        idle(3);
        check("r37_err", 64'(n_err), 0);
        check("r37_done", 64'(n_done), 1);

        clr();
        send(good, 0);
        send(good, 0);
        idle(3);
        check("b2b_done", 64'(n_done), 2);

        clr();
        send('{8'hAA, 8'h55, 8'h01}, 0);
        idle(TO + 10);
        check("to_err", 64'(n_err), 1);
        check("to_busy", 64'(parser_busy), 0);

        clr();
        send('{8'hAA, 8'h55, 8'h01, 8'h00, 8'h05, 8'h10, 8'h20}, 0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("rst_outs",
              {cmd_start, cmd_type, cmd_length, cmd_data, cmd_data_valid,
               cmd_data_index, cmd_done, cmd_error, parser_busy}, '0);
        idle(TO + 10);
        check("rst_pulses", 64'(n_done + n_err), 0);

        for (int i = 0; i < 400; i++) rand_frame();
        idle(TO + 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_frame_parser.md
CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

Interface
REQ-001 Parameter MAX_LEN, default 256: largest accepted payload length in bytes.
REQ-002 Parameter TIMEOUT_CYCLES, default 600000: idle clocks allowed inside a frame (10 ms at 60 MHz).
REQ-003 clk  input  1  system clock (USB PHY clock domain, 60 MHz).
REQ-004 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 usb_data_in  input  8  received byte from USB CDC.
REQ-006 usb_data_valid_in  input  1  byte strobe, one cycle per byte; no backpressure.
REQ-007 cmd_start  output  1  one-cycle pulse: valid header and length accepted.
REQ-008 cmd_type  output  8  command code of the current frame.
REQ-009 cmd_length  output  16  payload length of the current frame.
REQ-010 cmd_data  output  8  payload byte.
REQ-011 cmd_data_valid  output  1  one-cycle strobe qualifying cmd_data.
REQ-012 cmd_data_index  output  16  zero-based payload byte index, qualified by cmd_data_valid.
REQ-013 cmd_done  output  1  one-cycle pulse: frame complete, checksum correct.
REQ-014 cmd_error  output  1  one-cycle pulse: bad checksum, oversize length, or timeout.
REQ-015 parser_busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Frame format SHALL be: 0xAA, 0x55, cmd, len_hi, len_lo, payload[len], checksum.
REQ-017 Checksum SHALL be the low 8 bits of the modulo-256 sum of cmd, len_hi, len_lo and all payload bytes.
REQ-018 States SHALL be IDLE, HDR2, CMD, LEN_H, LEN_L, DATA, CKSUM; transitions occur only on usb_data_valid_in, except timeout.
REQ-019 IDLE: 0xAA -> HDR2; any other byte -> stay IDLE.
REQ-020 HDR2: 0x55 -> CMD; 0xAA -> stay HDR2; any other byte -> IDLE, no error pulse.
REQ-021 CMD: latch byte as type -> LEN_H; LEN_H: latch high byte -> LEN_L.
REQ-022 LEN_L: length > MAX_LEN -> cmd_error, go IDLE; length 0 -> cmd_start, go CKSUM; otherwise -> cmd_start, go DATA.
REQ-023 cmd_type and cmd_length SHALL update together with cmd_start and hold until the next cmd_start.
REQ-024 DATA: each byte SHALL produce cmd_data_valid with cmd_data_index counting 0..len-1; after byte len-1 -> CKSUM.
REQ-025 CKSUM: match -> cmd_done; mismatch -> cmd_error; either case -> IDLE.
REQ-026 All outputs SHALL be registered: every pulse or strobe appears exactly one clock after the accepting byte's valid cycle.
REQ-027 cmd_done and cmd_error SHALL never assert in the same cycle; at most one pulse per frame.
REQ-028 Timeout counter: clear on every valid byte and in IDLE; increment otherwise.
REQ-029 Counter reaching TIMEOUT_CYCLES outside IDLE -> cmd_error pulse, go IDLE; a valid byte in that same cycle is ignored.
REQ-030 Back-to-back frames, with 0xAA arriving the cycle after the checksum byte, SHALL parse with no lost bytes.

Reset
REQ-031 On rst_n low at a clk edge, regardless of state: state=IDLE, checksum accumulator=0, timeout counter=0, all outputs=0.
REQ-032 Reset mid-frame SHALL discard the partial frame with no cmd_done or cmd_error pulse.

Verification
REQ-033 AA 55 01 00 02 10 20 33 -> cmd_start, type=0x01, length=2; data 0x10 at idx 0, 0x20 at idx 1; cmd_done once.
REQ-034 Same frame with checksum 0x34 -> both data strobes, then cmd_error; no cmd_done.
REQ-035 AA 55 05 00 00 05 -> cmd_start with length=0; no cmd_data_valid; cmd_done.
REQ-036 AA 55 07 01 01 -> cmd_error after len_lo (257 > 256), no cmd_start; following frame from REQ-033 parses correctly.
REQ-037 Resync: 12 AA 34 AA AA 55 then the REQ-033 body -> no error pulses; single cmd_done.
REQ-038 AA 55 01, then silence for TIMEOUT_CYCLES -> cmd_error, parser_busy=0; rst_n low mid-payload -> all outputs 0, no pulse.
